// File: rtl/alu_fsm_pkg.sv
// alu_fsm_pkg: opcodes, FSM state encoding and opcode helpers shared by alu_fsm_seq and alu_iter_unit.
package alu_fsm_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_LSL = 4'd8;
  localparam logic [3:0] OP_LSR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ITER = 2'd2
  } state_t;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op > OP_ASR);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shared shift-add (MUL) / restoring shift-subtract (DIV) datapath, one bit per step.
// Exposes the post-step value so the parent can capture the final result on the last edge.
module alu_iter_unit
  import alu_fsm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_div;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_op1;
  logic [WIDTH:0]   w_op2;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi_nx;
  logic [WIDTH-1:0] w_lo_nx;

  // One adder serves both ops: DIV adds ~B+1 to the shifted remainder, MUL adds B when the multiplier LSB is set.
  always_comb begin
    w_op1   = {1'b0, r_hi};
    w_op2   = {(WIDTH+1){1'b0}};
    w_cin   = 1'b0;
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_div) begin
      w_op1 = {r_hi, r_lo[WIDTH-1]};
      w_op2 = ~{1'b0, r_b};
      w_cin = 1'b1;
    end else begin
      if (r_lo[0]) begin
        w_op2 = {1'b0, r_b};
      end else begin
        w_op2 = {(WIDTH+1){1'b0}};
      end
    end
    w_sum = w_op1 + w_op2 + {{WIDTH{1'b0}}, w_cin};
    if (r_div) begin
      if (w_sum[WIDTH]) begin
        w_hi_nx = w_op1[WIDTH-1:0];
      end else begin
        w_hi_nx = w_sum[WIDTH-1:0];
      end
      w_lo_nx = {r_lo[WIDTH-2:0], ~w_sum[WIDTH]};
    end else begin
      w_hi_nx = w_sum[WIDTH:1];
      w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_result = {w_hi_nx, w_lo_nx};
  assign o_last   = (r_cnt == {{(CW-1){1'b0}}, 1'b1});

  // Accumulator and iteration counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi  <= {WIDTH{1'b0}};
      r_lo  <= {WIDTH{1'b0}};
      r_b   <= {WIDTH{1'b0}};
      r_div <= 1'b0;
      r_cnt <= {CW{1'b0}};
    end else if (i_load) begin
      r_hi  <= {WIDTH{1'b0}};
      r_lo  <= i_a;
      r_b   <= i_b;
      r_div <= (i_op == OP_DIV);
      r_cnt <= CW'(WIDTH);
    end else if (i_step) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/alu_fsm_seq.sv
// alu_fsm_seq: handshaked ALU; single-cycle ops complete via EXEC, MUL/DIV iterate WIDTH cycles in ITER.
// Define ALU_FAST_MUL_EN to send MUL through the single-cycle EXEC path instead.
module alu_fsm_seq
  import alu_fsm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         op_sel,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               err
);

  state_t             r_state;
  state_t             w_state_nx;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;

  logic               w_b_nz;
  logic               w_iter_op;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic               w_busy_nx;
  logic               w_done_nx;
  logic               w_wr;
  logic [2*WIDTH-1:0] w_exec_res;
  logic [2*WIDTH-1:0] w_iter_res;
  logic [2*WIDTH-1:0] w_wr_res;
  logic               w_exec_err;
  logic               w_exec_c;
  logic               w_wr_err;
  logic               w_wr_c;
  logic [WIDTH:0]     w_addsub;
  logic [WIDTH-1:0]   w_narrow;

  assign w_b_nz = (B != {WIDTH{1'b0}});
`ifdef ALU_FAST_MUL_EN
  assign w_iter_op = (op_sel == OP_DIV) && w_b_nz;
`else
  assign w_iter_op = ((op_sel == OP_DIV) || (op_sel == OP_MUL)) && w_b_nz;
`endif

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_op     (op_sel),
    .i_a      (A),
    .i_b      (B),
    .o_last   (w_last),
    .o_result (w_iter_res)
  );

  // Single-cycle result from the latched operands; DIV only reaches here with B == 0.
  always_comb begin
    w_exec_res = {(2*WIDTH){1'b0}};
    w_exec_err = 1'b0;
    w_exec_c   = 1'b0;
    w_addsub   = {(WIDTH+1){1'b0}};
    w_narrow   = {WIDTH{1'b0}};
    case (r_op)
      OP_ADD: begin
        w_addsub   = {1'b0, r_a} + {1'b0, r_b};
        w_exec_res = {{(WIDTH-1){1'b0}}, w_addsub};
        w_exec_c   = w_addsub[WIDTH];
      end
      OP_SUB: begin
        w_addsub   = {1'b0, r_a} - {1'b0, r_b};
        w_exec_res = {{(WIDTH-1){1'b0}}, w_addsub};
        w_exec_c   = w_addsub[WIDTH];
      end
`ifdef ALU_FAST_MUL_EN
      OP_MUL: w_exec_res = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
`else
      OP_MUL: w_exec_res = {(2*WIDTH){1'b0}};
`endif
      OP_DIV: begin
        w_exec_res = {r_a, {WIDTH{1'b1}}};
        w_exec_err = 1'b1;
      end
      OP_AND: begin
        w_narrow   = r_a & r_b;
        w_exec_res = {{WIDTH{1'b0}}, w_narrow};
      end
      OP_OR: begin
        w_narrow   = r_a | r_b;
        w_exec_res = {{WIDTH{1'b0}}, w_narrow};
      end
      OP_XOR: begin
        w_narrow   = r_a ^ r_b;
        w_exec_res = {{WIDTH{1'b0}}, w_narrow};
      end
      OP_NOT: begin
        w_narrow   = ~r_a;
        w_exec_res = {{WIDTH{1'b0}}, w_narrow};
      end
      OP_LSL: begin
        w_narrow   = r_a << r_b[SHW-1:0];
        w_exec_res = {{WIDTH{1'b0}}, w_narrow};
      end
      OP_LSR: begin
        w_narrow   = r_a >> r_b[SHW-1:0];
        w_exec_res = {{WIDTH{1'b0}}, w_narrow};
      end
      OP_ASR: begin
        w_narrow   = $signed(r_a) >>> r_b[SHW-1:0];
        w_exec_res = {{WIDTH{w_narrow[WIDTH-1]}}, w_narrow};
      end
      default: begin
        w_exec_res = {(2*WIDTH){1'b0}};
        w_exec_err = is_reserved(r_op);
      end
    endcase
  end

  // Next state and the values the output registers take on this edge.
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_busy_nx  = busy;
    w_done_nx  = 1'b0;
    w_wr       = 1'b0;
    w_wr_res   = w_exec_res;
    w_wr_err   = w_exec_err;
    w_wr_c     = w_exec_c;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_busy_nx = 1'b1;
          if (w_iter_op) begin
            w_load     = 1'b1;
            w_state_nx = S_ITER;
          end else begin
            w_state_nx = S_EXEC;
          end
        end else begin
          w_busy_nx = 1'b0;
        end
      end
      S_EXEC: begin
        w_wr       = 1'b1;
        w_done_nx  = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
      S_ITER: begin
        w_step   = 1'b1;
        w_wr_res = w_iter_res;
        w_wr_err = 1'b0;
        w_wr_c   = 1'b0;
        if (w_last) begin
          w_wr       = 1'b1;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_busy_nx = 1'b1;
        end
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Registered outputs and operand latch; operands only move while IDLE so a start during busy has no effect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= {(2*WIDTH){1'b0}};
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      err    <= 1'b0;
      r_op   <= 4'd0;
      r_a    <= {WIDTH{1'b0}};
      r_b    <= {WIDTH{1'b0}};
    end else begin
      busy <= w_busy_nx;
      done <= w_done_nx;
      if (w_wr) begin
        result <= w_wr_res;
        flag_z <= (w_wr_res == {(2*WIDTH){1'b0}});
        flag_c <= w_wr_c;
        err    <= w_wr_err;
      end
      if ((r_state == S_IDLE) && start) begin
        r_op <= op_sel;
        r_a  <= A;
        r_b  <= B;
      end
    end
  end

endmodule

// File: tb/tb_alu_fsm_seq.sv
// tb_alu_fsm_seq: directed scoreboard bench for alu_fsm_seq (WIDTH=16); honours ALU_FAST_MUL_EN.
module tb_alu_fsm_seq;

`ifdef ALU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        e;
    int          due;
    int          bcy;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  op_sel;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        flag_z;
  logic        flag_c;
  logic        err;

  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];

  alu_fsm_seq dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op_sel (op_sel),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (busy) busy_cnt++;
  endtask

  function automatic int lat_of(input logic [3:0] op, input logic [15:0] b);
    if (b != 16'd0 && (op == 4'd3 || (op == 4'd2 && !FAST))) return 16;
    return 1;
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        x;
    logic [16:0] t;
    logic [15:0] s;
    x.res = 32'd0; x.c = 1'b0; x.e = 1'b0;
    case (op)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; x.res = {15'd0, t}; x.c = t[16]; end
      4'd1: begin t = {1'b0, a} - {1'b0, b}; x.res = {15'd0, t}; x.c = t[16]; end
      4'd2: x.res = {16'd0, a} * {16'd0, b};
      4'd3: begin
        if (b == 16'd0) begin x.res = {a, 16'hFFFF}; x.e = 1'b1; end
        else begin x.res[15:0] = a / b; x.res[31:16] = a % b; end
      end
      4'd4: x.res = {16'd0, a & b};
      4'd5: x.res = {16'd0, a | b};
      4'd6: x.res = {16'd0, a ^ b};
      4'd7: x.res = {16'd0, ~a};
      4'd8: x.res = {16'd0, a << b[3:0]};
      4'd9: x.res = {16'd0, a >> b[3:0]};
      4'd10: begin
        s = a;
        for (int i = 0; i < 16; i++) if (i < int'(b[3:0])) s = {s[15], s[15:1]};
        x.res = {{16{a[15]}}, s};
      end
      default: x.e = 1'b1;
    endcase
    x.z = (x.res == 32'd0);
    return x;
  endfunction

  task automatic go(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    tick();
    op_sel = op; A = a; B = b; start = 1'b1;
    busy_cnt = 0;
  endtask

  task automatic go_end();
    tick();
    start = 1'b0;
  endtask

  task automatic expect_model(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t x;
    x = model(op, a, b);
    x.tag = tag;
    x.bcy = lat_of(op, b);
    x.due = cyc + 1 + x.bcy;
    q.push_back(x);
  endtask

  task automatic expect_const(input string tag, input logic [31:0] res, input logic z, input logic c,
                              input logic e, input int lat);
    exp_t x;
    x.tag = tag; x.res = res; x.z = z; x.c = c; x.e = e; x.bcy = lat; x.due = cyc + 1 + lat;
    q.push_back(x);
  endtask

  task automatic take_done();
    exp_t x;
    x = q.pop_front();
    chk({x.tag, "/result"}, 64'(result), 64'(x.res));
    chk({x.tag, "/flag_z"}, 64'(flag_z), 64'(x.z));
    chk({x.tag, "/flag_c"}, 64'(flag_c), 64'(x.c));
    chk({x.tag, "/err"}, 64'(err), 64'(x.e));
    chk({x.tag, "/done_cycle"}, 64'(cyc), 64'(x.due));
    chk({x.tag, "/busy_cycles"}, 64'(busy_cnt), 64'(x.bcy));
    busy_cnt = 0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 60) begin
      tick();
      guard++;
      if (done) begin
        take_done();
        tick();
        chk("done_pulse", 64'(done), 64'd0);
      end
    end
    if (q.size() != 0) begin
      chk("timeout_pending", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    go(op, a, b);
    expect_model(tag, op, a, b);
    go_end();
    drain();
  endtask

  logic [3:0]  t_op [12] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
  logic [15:0] t_a  [12] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h1234, 16'h0123, 16'h8001, 16'h7000,
                             16'h0000, 16'h1234, 16'hABCD, 16'hFFFF, 16'h5555};
  logic [15:0] t_b  [12] = '{16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h0000, 16'h0004, 16'h000F, 16'h0003,
                             16'h0000, 16'h1234, 16'h0000, 16'h0001, 16'h5555};

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    reset_n = 1'b0; start = 1'b0; op_sel = 4'd0; A = 16'd0; B = 16'd0;
    tick(); tick();
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/result", 64'(result), 64'd0);
    chk("rst/flags", 64'({flag_z, flag_c}), 64'd0);
    chk("rst/err", 64'(err), 64'd0);
    reset_n = 1'b1;
    tick();

    go(4'd0, 16'hFFFF, 16'h0001); expect_const("add_carry", 32'h0001_0000, 1'b0, 1'b1, 1'b0, 1); go_end(); drain();
    go(4'd1, 16'd5, 16'd7);       expect_const("sub_borrow", 32'h0001_FFFE, 1'b0, 1'b1, 1'b0, 1); go_end(); drain();
    go(4'd10, 16'h8000, 16'd1);   expect_const("asr_neg", 32'hFFFF_C000, 1'b0, 1'b0, 1'b0, 1); go_end(); drain();
    go(4'd2, 16'd300, 16'd500);   expect_const("mul", 32'h0002_49F0, 1'b0, 1'b0, 1'b0, FAST ? 1 : 16); go_end(); drain();
    go(4'd3, 16'd1000, 16'd16);   expect_const("div", 32'h0008_003E, 1'b0, 1'b0, 1'b0, 16); go_end(); drain();
    go(4'd3, 16'd1234, 16'd0);    expect_const("div0", 32'h04D2_FFFF, 1'b0, 1'b0, 1'b1, 1); go_end(); drain();
    go(4'd12, 16'h1111, 16'h2222); expect_const("reserved", 32'h0, 1'b1, 1'b0, 1'b1, 1); go_end(); drain();

    for (int i = 0; i < 12; i++) run($sformatf("tbl%0d", i), t_op[i], t_a[i], t_b[i]);
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(1, 65535));
      run($sformatf("rnd%0d", i), (i % 2 == 0) ? 4'd2 : 4'd3, ra, rb);
    end

    // start pulsed mid-iteration must not disturb the running op
    go(FAST ? 4'd3 : 4'd2, 16'd300, 16'd500);
    expect_model("inflight", FAST ? 4'd3 : 4'd2, 16'd300, 16'd500);
    go_end();
    repeat (4) tick();
    op_sel = 4'd0; A = 16'd1; B = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    drain();
    tick();
    chk("ignored_start_idle", 64'(busy), 64'd0);

    // start held high: second op accepted in the IDLE cycle after done
    go(4'd0, 16'd1, 16'd2); expect_model("cont1", 4'd0, 16'd1, 16'd2);
    tick();
    chk("cont/busy1", 64'(busy), 64'd1);
    tick();
    chk("cont/done1", 64'(done), 64'd1);
    take_done();
    A = 16'd7; B = 16'd8;
    expect_model("cont2", 4'd0, 16'd7, 16'd8);
    tick();
    start = 1'b0;
    chk("cont/gap_done", 64'(done), 64'd0);
    chk("cont/busy2", 64'(busy), 64'd1);
    tick();
    chk("cont/done2", 64'(done), 64'd1);
    take_done();

    // asynchronous reset during DIV iteration 7
    go(4'd3, 16'd1234, 16'd0); expect_const("div0_again", 32'h04D2_FFFF, 1'b0, 1'b0, 1'b1, 1); go_end(); drain();
    go(4'd3, 16'd1000, 16'd16);
    go_end();
    repeat (6) tick();
    #1 reset_n = 1'b0;
    #1;
    chk("midrst/busy", 64'(busy), 64'd0);
    chk("midrst/done", 64'(done), 64'd0);
    chk("midrst/result", 64'(result), 64'd0);
    chk("midrst/err", 64'(err), 64'd0);
    start = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    go(4'd0, 16'd2, 16'd3); expect_const("add_after_rst", 32'd5, 1'b0, 1'b0, 1'b0, 1); go_end(); drain();
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
